pong_paddle_ctrl_accel: RTL and testbench

Parametrised next-generation Pong paddle controller: one instance per player, fed by the game-grid column/row divider and the debounced paddle buttons. It adds an acceleration state machine (slow steps, then fast steps while a button is held), an automatic ball-tracking mode for single-player games, and a defined reset position. It outputs the paddle row position to the ball/score logic and a registered draw strobe to the video mux.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_paddle_draw.sv | 45 ++++
 rtl/pong_paddle_ctrl_accel.sv | 162 ++++++++++++++++
 tb/tb_pong_paddle_ctrl_accel.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg : shared state/direction types for the Pong paddle controllers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } paddle_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } paddle_dir_e;

    // Counter width that stays legal (>= 1 bit) for degenerate periods.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pong_paddle_draw.sv
// ---------------------------------------------------------------------------
// pong_paddle_draw : registered paddle pixel comparator (one per paddle)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pong_paddle_draw #(
    parameter int c_PLAYER_PADDLE_X = 0,
    parameter int c_PADDLE_HEIGHT   = 6,
    parameter int c_COL_W           = 6,
    parameter int c_ROW_W           = 5
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [c_COL_W-1:0] i_Col,
    input  logic [c_ROW_W-1:0] i_Row,
    input  logic [c_ROW_W-1:0] i_Paddle_Y,
    output logic               o_Draw
);

    localparam logic [c_COL_W-1:0] c_X_COL  = c_COL_W'(c_PLAYER_PADDLE_X);
    localparam logic [c_ROW_W:0]   c_HEIGHT = (c_ROW_W+1)'(c_PADDLE_HEIGHT);

    logic               draw_q;
    logic [c_ROW_W:0]   w_bottom;
    logic               w_hit;

    // One bit wider so a paddle touching the last row cannot wrap.
    assign w_bottom = {1'b0, i_Paddle_Y} + c_HEIGHT;
    assign w_hit    = (i_Col == c_X_COL) && (i_Row >= i_Paddle_Y)
                      && ({1'b0, i_Row} < w_bottom);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            draw_q <= 1'b0;
        end else begin
            draw_q <= w_hit;
        end
    end

    assign o_Draw = draw_q;

endmodule

`default_nettype wire

// File: rtl/pong_paddle_ctrl_accel.sv
// ---------------------------------------------------------------------------
// pong_paddle_ctrl_accel : paddle controller with slow/fast acceleration
//                          and automatic ball tracking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pong_paddle_ctrl_accel
    import pong_pkg::*;
#(
    parameter int c_PLAYER_PADDLE_X = 0,
    parameter int c_PADDLE_HEIGHT   = 6,
    parameter int c_GAME_WIDTH      = 40,
    parameter int c_GAME_HEIGHT     = 30,
    parameter int c_SLOW_PERIOD     = 1250000,
    parameter int c_FAST_PERIOD     = 312500,
    parameter int c_ACCEL_STEPS     = 4,
    parameter int c_PADDLE_Y_INIT   = (c_GAME_HEIGHT - c_PADDLE_HEIGHT) / 2
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst,
    input  logic [$clog2(c_GAME_WIDTH)-1:0]  i_Col_Count_Div,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Row_Count_Div,
    input  logic                             i_Paddle_Up,
    input  logic                             i_Paddle_Dn,
    input  logic                             i_Auto_Mode,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Ball_Y,
    output logic                             o_Draw_Paddle,
    output logic [$clog2(c_GAME_HEIGHT)-1:0] o_Paddle_Y,
    output logic                             o_Moving
);

    localparam int c_COL_W  = $clog2(c_GAME_WIDTH);
    localparam int c_ROW_W  = $clog2(c_GAME_HEIGHT);
    localparam int c_CNT_W  = cnt_width(c_SLOW_PERIOD);
    localparam int c_STEP_W = cnt_width(c_ACCEL_STEPS + 1);

    localparam logic [c_CNT_W-1:0]  c_SLOW_LAST = c_CNT_W'(c_SLOW_PERIOD - 1);
    localparam logic [c_CNT_W-1:0]  c_FAST_LAST = c_CNT_W'(c_FAST_PERIOD - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_ROW_W-1:0]  c_Y_MAX     = c_ROW_W'(c_GAME_HEIGHT - c_PADDLE_HEIGHT);
    localparam logic [c_ROW_W-1:0]  c_Y_INIT    = c_ROW_W'(c_PADDLE_Y_INIT);
    localparam logic [c_ROW_W-1:0]  c_ROW_ONE   = c_ROW_W'(1);
    localparam logic [c_ROW_W:0]    c_HALF_H    = (c_ROW_W+1)'(c_PADDLE_HEIGHT / 2);
    localparam logic [c_STEP_W-1:0] c_STEP_SAT  = c_STEP_W'(c_ACCEL_STEPS);
    localparam logic [c_STEP_W-1:0] c_STEP_ONE  = c_STEP_W'(1);

    paddle_state_e       state_q;
    paddle_dir_e         dir_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic [c_STEP_W-1:0] steps_q;
    logic [c_ROW_W-1:0]  y_q;
    logic                moving_q;
    logic                auto_q;

    paddle_dir_e         req_dir_d;
    logic [c_ROW_W:0]    w_centre;
    logic [c_CNT_W-1:0]  w_period_last;
    logic                w_blocked;

    always_comb begin
        req_dir_d = DIR_NONE;
        w_centre  = {1'b0, y_q} + c_HALF_H;
        if (i_Auto_Mode) begin
            if ({1'b0, i_Ball_Y} < w_centre) begin
                req_dir_d = DIR_UP;
            end else if ({1'b0, i_Ball_Y} > w_centre) begin
                req_dir_d = DIR_DN;
            end
        end else if (i_Paddle_Up && !i_Paddle_Dn) begin
            req_dir_d = DIR_UP;
        end else if (i_Paddle_Dn && !i_Paddle_Up) begin
            req_dir_d = DIR_DN;
        end
    end

    assign w_period_last = (state_q == FAST) ? c_FAST_LAST : c_SLOW_LAST;
    assign w_blocked     = ((dir_q == DIR_UP) && (y_q == '0))
                        || ((dir_q == DIR_DN) && (y_q == c_Y_MAX));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            dir_q    <= DIR_NONE;
            cnt_q    <= '0;
            steps_q  <= '0;
            y_q      <= c_Y_INIT;
            moving_q <= 1'b0;
            auto_q   <= 1'b0;
        end else begin
            auto_q <= i_Auto_Mode;
            if (i_Auto_Mode != auto_q) begin
                state_q  <= IDLE;
                dir_q    <= DIR_NONE;
                cnt_q    <= '0;
                steps_q  <= '0;
                moving_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q   <= '0;
                        steps_q <= '0;
                        if (req_dir_d != DIR_NONE) begin
                            state_q  <= SLOW;
                            dir_q    <= req_dir_d;
                            moving_q <= 1'b1;
                        end
                    end
                    default: begin
                        if (req_dir_d == DIR_NONE) begin
                            state_q  <= IDLE;
                            dir_q    <= DIR_NONE;
                            cnt_q    <= '0;
                            steps_q  <= '0;
                            moving_q <= 1'b0;
                        end else if (req_dir_d != dir_q) begin
                            // Reversal restarts acceleration without stepping.
                            state_q <= SLOW;
                            dir_q   <= req_dir_d;
                            cnt_q   <= '0;
                            steps_q <= '0;
                        end else if (cnt_q == w_period_last) begin
                            cnt_q <= '0;
                            if (!w_blocked) begin
                                y_q <= (dir_q == DIR_UP) ? (y_q - c_ROW_ONE) : (y_q + c_ROW_ONE);
                                if (steps_q != c_STEP_SAT) begin
                                    steps_q <= steps_q + c_STEP_ONE;
                                end
                                if ((state_q == SLOW) && !i_Auto_Mode
                                    && (steps_q + c_STEP_ONE == c_STEP_SAT)) begin
                                    state_q <= FAST;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + c_CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    pong_paddle_draw #(
        .c_PLAYER_PADDLE_X (c_PLAYER_PADDLE_X),
        .c_PADDLE_HEIGHT   (c_PADDLE_HEIGHT),
        .c_COL_W           (c_COL_W),
        .c_ROW_W           (c_ROW_W)
    ) u_draw (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Col      (i_Col_Count_Div),
        .i_Row      (i_Row_Count_Div),
        .i_Paddle_Y (y_q),
        .o_Draw     (o_Draw_Paddle)
    );

    assign o_Paddle_Y = y_q;
    assign o_Moving   = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_paddle_ctrl_accel.sv
// ---------------------------------------------------------------------------
// tb_pong_paddle_ctrl_accel : directed scoreboard bench for the paddle ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pong_paddle_ctrl_accel;

    localparam int K_Y    = 0;
    localparam int K_MOV  = 1;
    localparam int K_DRAW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] col = 6'd5;
    logic [4:0] row = 5'd0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic       auto_m = 1'b0;
    logic [4:0] ball = 5'd0;
    logic       draw;
    logic [4:0] y_o;
    logic       moving;

    int edge_n   = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int    tgt;
        int    kind;
        int    val;
        string nm;
    } exp_t;

    exp_t sb[$];

    pong_paddle_ctrl_accel #(
        .c_PLAYER_PADDLE_X (0),
        .c_PADDLE_HEIGHT   (6),
        .c_GAME_WIDTH      (40),
        .c_GAME_HEIGHT     (30),
        .c_SLOW_PERIOD     (8),
        .c_FAST_PERIOD     (2),
        .c_ACCEL_STEPS     (3),
        .c_PADDLE_Y_INIT   (12)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Col_Count_Div (col),
        .i_Row_Count_Div (row),
        .i_Paddle_Up     (up),
        .i_Paddle_Dn     (dn),
        .i_Auto_Mode     (auto_m),
        .i_Ball_Y        (ball),
        .o_Draw_Paddle   (draw),
        .o_Paddle_Y      (y_o),
        .o_Moving        (moving)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: retire every expectation due at the edge just taken.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= edge_n) begin
            exp_t cur;
            int   act;
            cur = sb.pop_front();
            case (cur.kind)
                K_Y:     act = int'(y_o);
                K_MOV:   act = int'(moving);
                default: act = int'(draw);
            endcase
            checks++;
            if (cur.tgt != edge_n || act != cur.val) begin
                failures++;
                $display("FAIL %s edge=%0d due=%0d got=%0d expected=%0d",
                         cur.nm, edge_n, cur.tgt, act, cur.val);
            end
        end
    end

    task automatic push(input int t, input int kind, input int v, input string nm);
        exp_t e;
        int   i;
        e.tgt = t; e.kind = kind; e.val = v; e.nm = nm;
        i = 0;
        while (i < sb.size() && sb[i].tgt <= t) i++;
        sb.insert(i, e);
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        int k;
        rst = 1'b1; up = 1'b0; dn = 1'b0; auto_m = 1'b0; col = 6'd5;
        k = edge_n + 1;
        push(k, K_Y, 12, "rst_y");
        push(k, K_MOV, 0, "rst_moving");
        push(k, K_DRAW, 0, "rst_draw");
        wait_edge(k);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d got=timeout expected=finish", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        @(negedge clk);
        #1;
        do_reset();

        // Hold Up: three slow steps, then fast every 2 clocks.
        up = 1'b1; k = edge_n + 1;
        push(k, K_MOV, 1, "up_moving");
        push(k + 7, K_Y, 12, "up_y7");
        push(k + 8, K_Y, 11, "up_y8");
        push(k + 16, K_Y, 10, "up_y16");
        push(k + 24, K_Y, 9, "up_y24");
        push(k + 25, K_Y, 9, "up_y25");
        push(k + 26, K_Y, 8, "up_y26");
        push(k + 28, K_Y, 7, "up_y28");
        wait_edge(k + 28);
        up = 1'b0; k = edge_n + 1;
        push(k, K_MOV, 0, "rel_moving");
        push(k + 5, K_Y, 7, "rel_y_held");
        wait_edge(k + 5);

        // Reset in the middle of a move at Y=10.
        do_reset();
        up = 1'b1; k = edge_n + 1;
        push(k + 16, K_Y, 10, "mid_y10");
        wait_edge(k + 16);
        rst = 1'b1; up = 1'b0; k = edge_n + 1;
        push(k, K_Y, 12, "midrst_y");
        push(k, K_MOV, 0, "midrst_moving");
        wait_edge(k);
        rst = 1'b0;

        // Both buttons: no request.
        up = 1'b1; dn = 1'b1; k = edge_n + 1;
        push(k, K_MOV, 0, "both_moving");
        push(k + 39, K_Y, 12, "both_y");
        push(k + 39, K_MOV, 0, "both_moving_end");
        wait_edge(k + 40);
        up = 1'b0; dn = 1'b0;
        wait_edge(edge_n + 2);

        // Up for 5 clocks then Dn: reversal restarts the slow period.
        up = 1'b1; k = edge_n + 1;
        push(k, K_MOV, 1, "rev_moving");
        push(k + 8, K_Y, 12, "rev_no_step8");
        push(k + 12, K_Y, 12, "rev_y12");
        push(k + 13, K_Y, 13, "rev_y13");
        wait_edge(k + 4);
        up = 1'b0; dn = 1'b1;
        wait_edge(k + 13);
        dn = 1'b0;
        push(k + 14, K_MOV, 0, "rev_idle");
        wait_edge(k + 16);

        // Dn to the bottom limit and hold there.
        dn = 1'b1; k = edge_n + 1;
        push(k + 39, K_Y, 23, "dn_y39");
        push(k + 40, K_Y, 24, "dn_y40");
        push(k + 60, K_Y, 24, "dn_blocked");
        push(k + 60, K_MOV, 1, "dn_blocked_moving");
        wait_edge(k + 60);
        dn = 1'b0;
        wait_edge(edge_n + 2);

        // Up from the bottom to the top limit.
        up = 1'b1; k = edge_n + 1;
        push(k + 24, K_Y, 21, "top_y24");
        push(k + 66, K_Y, 0, "top_y66");
        push(k + 90, K_Y, 0, "top_blocked");
        push(k + 90, K_MOV, 1, "top_blocked_moving");
        wait_edge(k + 90);
        up = 1'b0;
        wait_edge(edge_n + 2);

        // Auto mode tracking ball row 3 from Y=12: slow steps only.
        do_reset();
        auto_m = 1'b1; ball = 5'd3; k = edge_n + 1;
        push(k, K_MOV, 0, "auto_enter_idle");
        push(k + 1, K_MOV, 1, "auto_moving");
        push(k + 9, K_Y, 11, "auto_y9");
        push(k + 17, K_Y, 10, "auto_y17");
        push(k + 25, K_Y, 9, "auto_y25");
        push(k + 27, K_Y, 9, "auto_no_fast");
        push(k + 33, K_Y, 8, "auto_y33");
        push(k + 97, K_Y, 0, "auto_y0");
        push(k + 97, K_MOV, 1, "auto_moving_last");
        push(k + 98, K_MOV, 0, "auto_idle");
        push(k + 110, K_Y, 0, "auto_y_hold");
        wait_edge(k + 110);

        // Toggling auto mid-move forces IDLE for one edge.
        ball = 5'd20; k = edge_n + 1;
        push(k, K_MOV, 1, "tog_moving");
        push(k + 5, K_MOV, 0, "tog_idle");
        push(k + 5, K_Y, 0, "tog_y");
        push(k + 6, K_MOV, 1, "tog_manual_moving");
        push(k + 20, K_Y, 0, "tog_y_blocked");
        wait_edge(k + 4);
        auto_m = 1'b0; up = 1'b1;
        wait_edge(k + 20);
        up = 1'b0;
        wait_edge(edge_n + 2);

        // Draw comparator at Y=12.
        do_reset();
        col = 6'd0;
        for (int r = 11; r <= 18; r++) begin
            row = 5'(r); k = edge_n + 1;
            push(k, K_DRAW, (r >= 12 && r <= 17) ? 1 : 0, $sformatf("draw_row%0d", r));
            wait_edge(k);
        end
        col = 6'd1; row = 5'd14; k = edge_n + 1;
        push(k, K_DRAW, 0, "draw_col_off");
        wait_edge(k);

        // Move to Y=24 and probe the last rows.
        col = 6'd5; dn = 1'b1; k = edge_n + 1;
        push(k + 42, K_Y, 24, "draw_move_y24");
        wait_edge(k + 50);
        dn = 1'b0;
        wait_edge(edge_n + 2);
        col = 6'd0; row = 5'd29; k = edge_n + 1;
        push(k, K_DRAW, 1, "draw_row29");
        wait_edge(k);
        row = 5'd23; k = edge_n + 1;
        push(k, K_DRAW, 0, "draw_row23");
        wait_edge(k);
        row = 5'd24; k = edge_n + 1;
        push(k, K_DRAW, 1, "draw_row24");
        wait_edge(k + 2);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
